uart_load_ctrl: RTL and testbench

UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

---
 rtl/uart_load_pkg.sv | 23 ++
 rtl/load_timeout.sv | 30 +++
 rtl/uart_load_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_load_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_load_pkg.sv
// Shared types and constants for the UART program/data loader.
package uart_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CNT = 3'd1,
    ST_GET_HI  = 3'd2,
    ST_GET_LO  = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  // Command bytes recognised in IDLE (and HALT in RUN)
  localparam logic [7:0] CMD_HALT      = 8'hA0;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'hA1;
  localparam logic [7:0] CMD_LOAD_IMEM = 8'hA2;
  localparam logic [7:0] CMD_RUN       = 8'hA5;

  // uart_sel target encodings
  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_DMEM = 2'd1;
  localparam logic [1:0] SEL_IMEM = 2'd2;

endpackage

// File: rtl/load_timeout.sv
// Inter-byte gap counter: counts idle cycles while a frame is open.
module load_timeout #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  // expired is raw; the controller gives an arriving byte priority over it
  assign expired = run && (cnt_q == TIMEOUT - 16'd1);

  // Counter only advances while run is high; otherwise it is held at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run || expired) cnt_d = 16'd0;
    else                          cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_load_ctrl.sv
// UART loader: parses command frames into 16-bit word writes and
// controls the CPU hold line.
module uart_load_ctrl
  import uart_load_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        uart_en,
  output logic [1:0]  uart_sel,
  output logic [15:0] uart_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        err
);

  state_t      state_q, state_d;
  logic [1:0]  target_q, target_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  hi_q, hi_d;
  logic        err_q, err_d;
  logic        en_q, en_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] data_q, data_d;
  logic        in_frame;
  logic        tmo_expired;

  assign in_frame  = (state_q == ST_GET_CNT) || (state_q == ST_GET_HI) ||
                     (state_q == ST_GET_LO);
  assign busy      = in_frame;
  assign cpu_hold  = (state_q != ST_RUN);
  assign err       = err_q;
  assign uart_en   = en_q;
  assign uart_sel  = sel_q;
  assign uart_data = data_q;

  load_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid),
    .run     (in_frame),
    .expired (tmo_expired)
  );

  // Next-state and strobe logic; strobe fields are zero unless a word completes
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    err_d       = err_q;
    en_d        = 1'b0;
    sel_d       = SEL_IDLE;
    data_d      = 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_LOAD_DMEM: begin
              target_d = SEL_DMEM;
              err_d    = 1'b0;
              state_d  = ST_GET_CNT;
            end
            CMD_LOAD_IMEM: begin
              target_d = SEL_IMEM;
              err_d    = 1'b0;
              state_d  = ST_GET_CNT;
            end
            CMD_RUN: begin
              err_d   = 1'b0;
              state_d = ST_RUN;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_GET_CNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            remaining_d = rx_byte;
            state_d     = ST_GET_HI;
          end
        end
      end
      ST_GET_HI: begin
        if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = ST_GET_LO;
        end
      end
      ST_GET_LO: begin
        if (rx_valid) begin
          en_d        = 1'b1;
          sel_d       = target_q;
          data_d      = {hi_q, rx_byte};
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? ST_IDLE : ST_GET_HI;
        end
      end
      ST_RUN: begin
        if (rx_valid && rx_byte == CMD_HALT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Gap timeout aborts the frame unless a byte arrives this same cycle
    if (in_frame && !rx_valid && tmo_expired) begin
      state_d     = ST_IDLE;
      err_d       = 1'b1;
      hi_d        = 8'd0;
      remaining_d = 8'd0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= SEL_IDLE;
      remaining_q <= 8'd0;
      hi_q        <= 8'd0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      sel_q       <= SEL_IDLE;
      data_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed bench for uart_load_ctrl with a short gap timeout.
module tb_uart_load_ctrl;

  localparam logic [15:0] T = 16'd20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        uart_en;
  logic [1:0]  uart_sel;
  logic [15:0] uart_data;
  logic        cpu_hold;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int en_seen = 0;
  int idle_bus_bad = 0;
  int e0;

  always #5 clk = ~clk;

  uart_load_ctrl #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .uart_en   (uart_en),
    .uart_sel  (uart_sel),
    .uart_data (uart_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .err       (err)
  );

  // Count strobes and any non-zero sel/data outside a strobe
  always @(negedge clk) begin
    if (uart_en === 1'b1) en_seen++;
    else if (uart_sel !== 2'd0 || uart_data !== 16'd0) idle_bus_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is consumed at the next posedge,
  // returns at the following negedge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, ".en"},   32'(uart_en),  32'd0);
    chk({tag, ".sel"},  32'(uart_sel), 32'd0);
    chk({tag, ".data"}, 32'(uart_data), 32'd0);
    chk({tag, ".busy"}, 32'(busy),     32'd0);
    chk({tag, ".err"},  32'(err),      32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    idle(1);

    // Two-word instruction memory load, back-to-back bytes
    send(8'hA2);
    chk("a2.busy", 32'(busy), 32'd1);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("w0.en",   32'(uart_en),   32'd1);
    chk("w0.sel",  32'(uart_sel),  32'd2);
    chk("w0.data", 32'(uart_data), 32'h1234);
    send(8'hAB);
    chk("hi1.en",  32'(uart_en),   32'd0);
    chk("hi1.data", 32'(uart_data), 32'd0);
    send(8'hCD);
    chk("w1.en",   32'(uart_en),   32'd1);
    chk("w1.sel",  32'(uart_sel),  32'd2);
    chk("w1.data", 32'(uart_data), 32'hABCD);
    chk("w1.busy", 32'(busy),      32'd0);
    idle(1);
    chk("w1.en_after", 32'(uart_en), 32'd0);
    chk("w1.err",  32'(err),       32'd0);
    chk("w.pulses", 32'(en_seen),  32'd2);

    // Zero-count frame
    e0 = en_seen;
    send(8'hA1);
    send(8'h00);
    chk("n0.busy", 32'(busy), 32'd0);
    idle(2);
    chk("n0.pulses", 32'(en_seen - e0), 32'd0);
    chk("n0.err",  32'(err),  32'd0);

    // Unknown command in IDLE
    send(8'h3C);
    chk("bad.err",  32'(err),      32'd1);
    chk("bad.busy", 32'(busy),     32'd0);
    chk("bad.hold", 32'(cpu_hold), 32'd1);

    // Load header clears err; then timeout after partial word
    e0 = en_seen;
    send(8'hA1);
    chk("hdr.clr_err", 32'(err), 32'd0);
    send(8'h01);
    send(8'h55);
    idle(int'(T) - 1);
    chk("tmo.pre_err",  32'(err),  32'd0);
    chk("tmo.pre_busy", 32'(busy), 32'd1);
    idle(1);
    chk("tmo.err",  32'(err),  32'd1);
    chk("tmo.busy", 32'(busy), 32'd0);
    idle(1);
    chk("tmo.pulses", 32'(en_seen - e0), 32'd0);
    send(8'hA1);
    chk("tmo.clr_err", 32'(err), 32'd0);
    send(8'h00);

    // Byte arriving on the expiry cycle wins
    send(8'hA1);
    send(8'h01);
    idle(int'(T) - 1);
    send(8'h77);
    chk("race.busy", 32'(busy), 32'd1);
    chk("race.err",  32'(err),  32'd0);
    send(8'h88);
    chk("race.en",   32'(uart_en),   32'd1);
    chk("race.sel",  32'(uart_sel),  32'd1);
    chk("race.data", 32'(uart_data), 32'h7788);

    // Run / halt
    send(8'hA5);
    chk("run.hold", 32'(cpu_hold), 32'd0);
    chk("run.busy", 32'(busy),     32'd0);
    send(8'h11);
    chk("run.ign_hold", 32'(cpu_hold), 32'd0);
    chk("run.ign_err",  32'(err),      32'd0);
    idle(2 * int'(T));
    chk("run.no_tmo", 32'(err), 32'd0);
    send(8'hA0);
    chk("halt.hold", 32'(cpu_hold), 32'd1);
    send(8'h11);
    chk("halt.idle_err", 32'(err), 32'd1);

    // Reset mid-frame, with a byte presented in the reset cycle
    e0 = en_seen;
    send(8'hA2);
    send(8'h01);
    send(8'h12);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h34;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    chk_reset_vals("mid");
    reset = 1'b0;
    idle(2);
    chk("mid.pulses", 32'(en_seen - e0), 32'd0);
    send(8'h56);
    chk("mid.idle_err", 32'(err), 32'd1);

    chk("bus_zero_when_idle", 32'(idle_bus_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
